// File: rtl/instruction_fetch_unit_if.sv
// Bundle between the fetch unit, the instruction memory, the hazard/branch logic and decode.
// master = fetch unit side, slave = surrounding pipeline/memory side.
interface instruction_fetch_unit_if #(
    parameter int CNT_W = 16
);
    // Control inputs from hazard/EX logic
    logic             freeze;
    logic             branch_taken;
    logic [31:0]      branch_address;
    logic             flush;
    // Combinational instruction memory port
    logic [31:0]      imem_pc;
    logic [31:0]      imem_instruction;
    // IF/ID pipeline register towards decode
    logic             if_valid;
    logic [31:0]      if_pc;
    logic [31:0]      if_instruction;
    logic [CNT_W-1:0] fetch_count;
    logic             halted;
    // Fetch state for observation (0=RESET, 1=RUN, 2=HALT)
    logic [1:0]       dbg_state;

    modport master (
        input  freeze, branch_taken, branch_address, flush, imem_instruction,
        output imem_pc, if_valid, if_pc, if_instruction, fetch_count, halted, dbg_state
    );

    modport slave (
        output freeze, branch_taken, branch_address, flush, imem_instruction,
        input  imem_pc, if_valid, if_pc, if_instruction, fetch_count, halted, dbg_state
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Program counter and IF/ID register with freeze, branch redirect and flush.
// Optional macro FETCH_HALT_ON_ZERO_EN: a fetched all-zero word halts fetch until reset or branch.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4,
    parameter int          CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    instruction_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             if_valid_q, if_valid_d;
    logic [31:0]      if_pc_q, if_pc_d;
    logic [31:0]      if_instruction_q, if_instruction_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic halted_now;
    logic load_en;
    logic zero_halt;

    always_comb begin
        halted_now = (state_q == S_HALT);
        // While halted, freeze is irrelevant: nothing loads until a redirect.
        load_en    = !bus.flush && !bus.freeze && !halted_now;
`ifdef FETCH_HALT_ON_ZERO_EN
        zero_halt  = load_en && (bus.imem_instruction == 32'h0) && !bus.branch_taken;
`else
        zero_halt  = 1'b0;
`endif

        pc_d             = pc_q;
        if_valid_d       = if_valid_q;
        if_pc_d          = if_pc_q;
        if_instruction_d = if_instruction_q;
        fetch_count_d    = fetch_count_q;
        state_d          = state_q;

        // A redirect always wins over stall or halt so it is never lost.
        if (bus.branch_taken) begin
            pc_d = bus.branch_address;
        end else if (bus.freeze || halted_now || zero_halt) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_q + PC_STEP;
        end

        if (bus.flush) begin
            if_valid_d       = 1'b0;
            if_pc_d          = 32'h0;
            if_instruction_d = 32'h0;
        end else if (zero_halt) begin
            if_valid_d = 1'b0;
        end else if (load_en) begin
            if_valid_d       = 1'b1;
            if_pc_d          = pc_q + PC_STEP;
            if_instruction_d = bus.imem_instruction;
            fetch_count_d    = fetch_count_q + 1'b1;
        end

        if (halted_now && bus.branch_taken) begin
            state_d = S_RUN;
        end else if (zero_halt) begin
            state_d = S_HALT;
        end else if (state_q == S_RESET) begin
            state_d = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_RESET;
            pc_q             <= RESET_PC;
            if_valid_q       <= 1'b0;
            if_pc_q          <= 32'h0;
            if_instruction_q <= 32'h0;
            fetch_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            if_valid_q       <= if_valid_d;
            if_pc_q          <= if_pc_d;
            if_instruction_q <= if_instruction_d;
            fetch_count_q    <= fetch_count_d;
        end
    end

    assign bus.imem_pc        = pc_q;
    assign bus.if_valid       = if_valid_q;
    assign bus.if_pc          = if_pc_q;
    assign bus.if_instruction = if_instruction_q;
    assign bus.fetch_count    = fetch_count_q;
    assign bus.dbg_state      = state_q;
`ifdef FETCH_HALT_ON_ZERO_EN
    assign bus.halted         = halted_now;
`else
    assign bus.halted         = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small combinational instruction memory.
module tb_instruction_fetch_unit;
    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    instruction_fetch_unit_if #(.CNT_W(CNT_W)) bus ();

    instruction_fetch_unit #(
        .RESET_PC(32'd0),
        .PC_STEP (32'd4),
        .CNT_W   (CNT_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Memory contents: 0x0 and 0x4 fixed words, 0x9C (156) is zero,
    // other words below 256 are A0000000+addr, everything else reads DEADBEEF.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (addr == 32'd0)        return 32'hE3A0_0014;
        else if (addr == 32'd4)   return 32'hE3A0_1A01;
        else if (addr == 32'd156) return 32'h0000_0000;
        else if (addr < 32'd256)  return 32'hA000_0000 + addr;
        else                      return 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_instruction = mem_word(bus.imem_pc);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        errors             = 0;
        checks             = 0;
        rst_n              = 1'b0;
        bus.freeze         = 1'b0;
        bus.branch_taken   = 1'b0;
        bus.branch_address = 32'h0;
        bus.flush          = 1'b0;
        do_reset();

        // Reset state
        check("rst_pc",    bus.imem_pc, 32'h0);
        check("rst_valid", 32'(bus.if_valid), 32'h0);
        check("rst_ifpc",  bus.if_pc, 32'h0);
        check("rst_instr", bus.if_instruction, 32'h0);
        check("rst_count", 32'(bus.fetch_count), 32'h0);
        check("rst_halt",  32'(bus.halted), 32'h0);

        // Sequential fetch
        step();
        check("t1_pc1",    bus.imem_pc, 32'd4);
        check("t1_instr1", bus.if_instruction, 32'hE3A0_0014);
        check("t1_ifpc1",  bus.if_pc, 32'd4);
        check("t1_valid1", 32'(bus.if_valid), 32'h1);
        step();
        check("t1_pc2",    bus.imem_pc, 32'd8);
        check("t1_instr2", bus.if_instruction, 32'hE3A0_1A01);
        check("t1_ifpc2",  bus.if_pc, 32'd8);
        check("t1_count",  32'(bus.fetch_count), 32'd2);

        // Freeze at PC=12
        step();
        check("t2_pc12", bus.imem_pc, 32'd12);
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2_frz_pc",    bus.imem_pc, 32'd12);
            check("t2_frz_instr", bus.if_instruction, 32'hA000_0008);
            check("t2_frz_ifpc",  bus.if_pc, 32'd12);
            check("t2_frz_count", 32'(bus.fetch_count), 32'd3);
        end
        bus.freeze = 1'b0;
        step();
        check("t2_rel_instr", bus.if_instruction, 32'hA000_000C);
        check("t2_rel_ifpc",  bus.if_pc, 32'd16);
        check("t2_rel_count", 32'(bus.fetch_count), 32'd4);

        // Run to PC=148, then branch+flush to 112
        for (int i = 0; i < 33; i++) step();
        check("t3_pc148", bus.imem_pc, 32'd148);
        check("t3_count", 32'(bus.fetch_count), 32'd37);
        bus.branch_taken   = 1'b1;
        bus.flush          = 1'b1;
        bus.branch_address = 32'd112;
        step();
        bus.branch_taken = 1'b0;
        bus.flush        = 1'b0;
        check("t3_br_pc",    bus.imem_pc, 32'd112);
        check("t3_br_valid", 32'(bus.if_valid), 32'h0);
        check("t3_br_instr", bus.if_instruction, 32'h0);
        check("t3_br_ifpc",  bus.if_pc, 32'h0);
        check("t3_br_count", 32'(bus.fetch_count), 32'd37);
        step();
        check("t3_ld_ifpc",  bus.if_pc, 32'd116);
        check("t3_ld_valid", 32'(bus.if_valid), 32'h1);
        check("t3_ld_instr", bus.if_instruction, 32'hA000_0070);
        check("t3_ld_count", 32'(bus.fetch_count), 32'd38);

        // Branch during freeze: redirect wins, IF/ID holds
        bus.branch_taken   = 1'b1;
        bus.freeze         = 1'b1;
        bus.branch_address = 32'd64;
        step();
        bus.freeze = 1'b0;
        check("t4_pc",    bus.imem_pc, 32'd64);
        check("t4_ifpc",  bus.if_pc, 32'd116);
        check("t4_instr", bus.if_instruction, 32'hA000_0070);
        check("t4_count", 32'(bus.fetch_count), 32'd38);

        // Branch without flush still loads the current word
        bus.branch_address = 32'd200;
        step();
        bus.branch_taken = 1'b0;
        check("t4b_pc",    bus.imem_pc, 32'd200);
        check("t4b_ifpc",  bus.if_pc, 32'd68);
        check("t4b_instr", bus.if_instruction, 32'hA000_0040);
        check("t4b_count", 32'(bus.fetch_count), 32'd39);

        // PC wrap at top of address space
        bus.branch_taken   = 1'b1;
        bus.flush          = 1'b1;
        bus.branch_address = 32'hFFFF_FFFC;
        step();
        bus.branch_taken = 1'b0;
        bus.flush        = 1'b0;
        check("wrap_pc_top", bus.imem_pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc",    bus.imem_pc, 32'h0);
        check("wrap_ifpc",  bus.if_pc, 32'h0);
        check("wrap_instr", bus.if_instruction, 32'hDEAD_BEEF);

        // Unaligned branch target passes through verbatim
        bus.branch_taken   = 1'b1;
        bus.flush          = 1'b1;
        bus.branch_address = 32'h0000_0042;
        step();
        bus.branch_taken = 1'b0;
        bus.flush        = 1'b0;
        check("unal_pc", bus.imem_pc, 32'h42);
        step();
        check("unal_ifpc", bus.if_pc, 32'h46);

        // Reset while frozen at PC=40 with count=10
        do_reset();
        for (int i = 0; i < 10; i++) step();
        check("t5_pc40",   bus.imem_pc, 32'd40);
        check("t5_cnt10",  32'(bus.fetch_count), 32'd10);
        bus.freeze = 1'b1;
        rst_n      = 1'b0;
        step();
        rst_n      = 1'b1;
        bus.freeze = 1'b0;
        check("t5_pc",    bus.imem_pc, 32'h0);
        check("t5_valid", 32'(bus.if_valid), 32'h0);
        check("t5_count", 32'(bus.fetch_count), 32'h0);
        check("t5_ifpc",  bus.if_pc, 32'h0);

        // Zero word at PC=156
        for (int i = 0; i < 39; i++) step();
        check("t6_pc156", bus.imem_pc, 32'd156);
        check("t6_cnt39", 32'(bus.fetch_count), 32'd39);
        step();
`ifdef FETCH_HALT_ON_ZERO_EN
        check("t6_halted", 32'(bus.halted), 32'h1);
        check("t6_pc",     bus.imem_pc, 32'd156);
        check("t6_valid",  32'(bus.if_valid), 32'h0);
        check("t6_count",  32'(bus.fetch_count), 32'd39);
        step();
        check("t6_hold_pc", bus.imem_pc, 32'd156);
        bus.freeze = 1'b1;
        step();
        bus.freeze = 1'b0;
        check("t6_frz_halted", 32'(bus.halted), 32'h1);
        check("t6_frz_count",  32'(bus.fetch_count), 32'd39);
        bus.branch_taken   = 1'b1;
        bus.branch_address = 32'd0;
        step();
        bus.branch_taken = 1'b0;
        check("t6_br_halted", 32'(bus.halted), 32'h0);
        check("t6_br_pc",     bus.imem_pc, 32'h0);
        check("t6_br_count",  32'(bus.fetch_count), 32'd39);
        step();
        check("t6_ld_instr", bus.if_instruction, 32'hE3A0_0014);
        check("t6_ld_ifpc",  bus.if_pc, 32'd4);
        check("t6_ld_valid", 32'(bus.if_valid), 32'h1);
        check("t6_ld_count", 32'(bus.fetch_count), 32'd40);
`else
        check("t6_halted", 32'(bus.halted), 32'h0);
        check("t6_valid",  32'(bus.if_valid), 32'h1);
        check("t6_instr",  bus.if_instruction, 32'h0);
        check("t6_ifpc",   bus.if_pc, 32'd160);
        check("t6_pc",     bus.imem_pc, 32'd160);
        check("t6_count",  32'(bus.fetch_count), 32'd40);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
